// File: rtl/mmc_card_tx_sched.sv
// mmc_card_tx_sched: write-direction block scheduler between the card data
// FIFO and the data-line transmit engine. Each block is held until the FIFO
// holds all of its words, then streamed to the engine, then the card's CRC
// status is awaited before the next block.
// Build option: define MMC_TX_SCHED_AUTO_FLUSH_EN to pulse fifo_flush_o on
// error entry and after an abort; otherwise fifo_flush_o stays 0.
module mmc_card_tx_sched #(
  parameter int TIMEOUT_W = 24,
  parameter int LEVEL_W   = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [15:0]          block_count_i,
  input  logic [7:0]           block_words_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic [LEVEL_W-1:0]   fifo_level_i,
  input  logic                 fifo_valid_i,
  input  logic [31:0]          fifo_data_i,
  output logic                 fifo_pop_o,
  output logic                 fifo_flush_o,
  output logic                 tx_start_o,
  output logic [31:0]          tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_accept_i,
  input  logic                 tx_done_i,
  input  logic                 tx_crc_ok_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [1:0]           err_code_o,
  output logic [15:0]          blocks_done_o
);

`ifdef MMC_TX_SCHED_AUTO_FLUSH_EN
  localparam logic AUTO_FLUSH = 1'b1;
`else
  localparam logic AUTO_FLUSH = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_LEVEL  = 3'd1,
    S_START       = 3'd2,
    S_STREAM      = 3'd3,
    S_WAIT_STATUS = 3'd4,
    S_DONE        = 3'd5,
    S_ERROR       = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          blk_cnt_q, blk_cnt_d;
  logic [7:0]           words_q, words_d;
  logic [7:0]           word_cnt_q, word_cnt_d;
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [15:0]          blocks_done_q, blocks_done_d;
  logic                 error_q, error_d;
  logic [1:0]           err_code_q, err_code_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tx_start_q, tx_start_d;
  logic                 flush_q, flush_d;

  logic                 stream_s;
  logic                 pop_s;
  logic                 level_ok_s;
  logic                 tmo_exp_s;
  logic                 abort_taken_s;
  logic [LEVEL_W-1:0]   words_need_s;

  // Streaming datapath is combinational so the engine sees the FIFO head directly.
  assign stream_s      = (state_q == S_STREAM);
  assign tx_valid_o    = stream_s & fifo_valid_i;
  assign tx_data_o     = stream_s ? fifo_data_i : 32'h0000_0000;
  assign pop_s         = tx_valid_o & tx_accept_i;
  assign fifo_pop_o    = pop_s;

  // A programmed word count of 0 stands for a full 256-word block.
  assign words_need_s  = (words_q == 8'd0) ? LEVEL_W'(256) : LEVEL_W'(words_q);
  assign level_ok_s    = (fifo_level_i >= words_need_s);
  // Expiry lands on the timeout_q-th cycle spent in a wait state; 0 disables it.
  assign tmo_exp_s     = (timeout_q != {TIMEOUT_W{1'b0}}) &&
                         (tmo_cnt_q == timeout_q - TIMEOUT_W'(1));
  assign abort_taken_s = abort_i & (state_q != S_IDLE);

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign err_code_o    = err_code_q;
  assign blocks_done_o = blocks_done_q;
  assign tx_start_o    = tx_start_q;
  assign fifo_flush_o  = flush_q;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d       = state_q;
    blk_cnt_d     = blk_cnt_q;
    words_d       = words_q;
    word_cnt_d    = word_cnt_q;
    timeout_d     = timeout_q;
    tmo_cnt_d     = tmo_cnt_q;
    blocks_done_d = blocks_done_q;
    error_d       = error_q;
    err_code_d    = err_code_q;

    if (abort_taken_s) begin
      // Abort overrides every other event; counters and flags are left alone.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            blk_cnt_d     = block_count_i;
            words_d       = block_words_i;
            timeout_d     = timeout_i;
            tmo_cnt_d     = {TIMEOUT_W{1'b0}};
            blocks_done_d = 16'd0;
            error_d       = 1'b0;
            err_code_d    = 2'b00;
            state_d       = (block_count_i == 16'd0) ? S_DONE : S_WAIT_LEVEL;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT_LEVEL: begin
          if (level_ok_s) begin
            state_d = S_START;
          end else if (tmo_exp_s) begin
            state_d    = S_ERROR;
            error_d    = 1'b1;
            err_code_d = 2'b01;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
          end
        end
        S_START: begin
          word_cnt_d = 8'd0;
          state_d    = S_STREAM;
        end
        S_STREAM: begin
          if (pop_s) begin
            word_cnt_d = word_cnt_q + 8'd1;
            // words_q - 1 wraps to 255 for a 256-word block.
            if (word_cnt_q == words_q - 8'd1) begin
              state_d   = S_WAIT_STATUS;
              tmo_cnt_d = {TIMEOUT_W{1'b0}};
            end else begin
              state_d = S_STREAM;
            end
          end else begin
            state_d = S_STREAM;
          end
        end
        S_WAIT_STATUS: begin
          if (tx_done_i) begin
            if (tx_crc_ok_i) begin
              blocks_done_d = blocks_done_q + 16'd1;
              if ((blocks_done_q + 16'd1) == blk_cnt_q) begin
                state_d = S_DONE;
              end else begin
                state_d   = S_WAIT_LEVEL;
                tmo_cnt_d = {TIMEOUT_W{1'b0}};
              end
            end else begin
              state_d    = S_ERROR;
              error_d    = 1'b1;
              err_code_d = 2'b11;
            end
          end else if (tmo_exp_s) begin
            state_d    = S_ERROR;
            error_d    = 1'b1;
            err_code_d = 2'b10;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        S_ERROR: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Registered outputs are decoded from the state being entered.
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    tx_start_d = (state_d == S_START);
    flush_d    = AUTO_FLUSH & (abort_taken_s | (state_d == S_ERROR));
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      blk_cnt_q     <= 16'd0;
      words_q       <= 8'd0;
      word_cnt_q    <= 8'd0;
      timeout_q     <= {TIMEOUT_W{1'b0}};
      tmo_cnt_q     <= {TIMEOUT_W{1'b0}};
      blocks_done_q <= 16'd0;
      error_q       <= 1'b0;
      err_code_q    <= 2'b00;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      blk_cnt_q     <= blk_cnt_d;
      words_q       <= words_d;
      word_cnt_q    <= word_cnt_d;
      timeout_q     <= timeout_d;
      tmo_cnt_q     <= tmo_cnt_d;
      blocks_done_q <= blocks_done_d;
      error_q       <= error_d;
      err_code_q    <= err_code_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      tx_start_q    <= tx_start_d;
      flush_q       <= flush_d;
    end
  end

endmodule
